bit_diff_rr_sched: RTL and testbench

//   Shares one bit-difference FSMD core (go/data -> done/result) among NUM_REQ requesters.
//   - Arbitration: round-robin.
//   - Sequencing: drives the core's go/data, waits for its done, returns the signed result
//     and the requester ID on a valid/ready response channel.
//   - Watchdog: aborts a job and flags an error if the core hangs.

---
 rtl/bit_diff_rr_sched.sv | 179 +++++++++++++++++
 tb/tb_bit_diff_rr_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_diff_rr_sched.sv
// bit_diff_rr_sched
//   Time-shares one bit-difference core among NUM_REQ requesters. A round-robin
//   arbiter accepts one job at a time in IDLE. The sequencer pulses core_go and
//   waits for core_done, then presents {id, result, error} on a valid/ready
//   response channel. A watchdog aborts jobs whose core never answers.
module bit_diff_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]            req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]          rsp_id,
  output logic signed [$clog2(2*WIDTH+1)-1:0] rsp_result,
  output logic                                rsp_error,
  output logic                                core_go,
  output logic [WIDTH-1:0]                    core_data,
  input  logic signed [$clog2(2*WIDTH+1)-1:0] core_result,
  input  logic                                core_done,
  output logic                                busy
);

  localparam int RW  = $clog2(2*WIDTH+1);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT+1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT-1);
  localparam logic [IDW-1:0] IDX_LAST = IDW'(NUM_REQ-1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [IDW-1:0]        ptr_r, ptr_s;
  logic [CW-1:0]         cnt_r, cnt_s;
  logic [WIDTH-1:0]      data_r, data_s;
  logic [IDW-1:0]        id_r, id_s;
  logic signed [RW-1:0]  res_r, res_s;
  logic                  err_r, err_s;
  logic                  go_r, rsp_valid_r, busy_r;
  logic                  grant_any_s;
  logic [IDW-1:0]        grant_idx_s;
  logic [NUM_REQ-1:0]    grant_vec_s;

  // Index reached by stepping 'off' places from 'base' around the requester ring.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return IDW'(sum % 32'(NUM_REQ));
  endfunction

  // Round-robin search: first asserted request starting at the pointer.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    for (int unsigned k = 0; k < 32'(NUM_REQ); k++) begin
      if (!grant_any_s && req_valid[rr_idx(ptr_r, k)]) begin
        grant_any_s = 1'b1;
        grant_idx_s = rr_idx(ptr_r, k);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // One-hot accept pulse, only while idle and never during reset.
  always_comb begin
    grant_vec_s = '0;
    if ((state_r == S_IDLE) && grant_any_s && !rst) begin
      grant_vec_s[grant_idx_s] = 1'b1;
    end else begin
      grant_vec_s = '0;
    end
  end

  // Sequencer next-state and datapath capture.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    id_s    = id_r;
    res_s   = res_r;
    err_s   = err_r;
    case (state_r)
      S_IDLE: begin
        if (grant_any_s) begin
          state_s = S_ISSUE;
          data_s  = req_data[int'(grant_idx_s)*WIDTH +: WIDTH];
          id_s    = grant_idx_s;
          if (grant_idx_s == IDX_LAST) begin
            ptr_s = '0;
          end else begin
            ptr_s = grant_idx_s + IDW'(1);
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_s = S_ARM;
      end
      S_ARM: begin
        // done may still be high from the previous job here; it is ignored
        cnt_s   = '0;
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          res_s   = core_result;
          err_s   = 1'b0;
          state_s = S_RESP;
        end else if (cnt_r == CNT_LAST) begin
          res_s   = '0;
          err_s   = 1'b1;
          state_s = S_RESP;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags; async reset aborts any job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      ptr_r       <= '0;
      cnt_r       <= '0;
      data_r      <= '0;
      id_r        <= '0;
      res_r       <= '0;
      err_r       <= 1'b0;
      go_r        <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      cnt_r       <= cnt_s;
      data_r      <= data_s;
      id_r        <= id_s;
      res_r       <= res_s;
      err_r       <= err_s;
      go_r        <= (state_s == S_ISSUE);
      rsp_valid_r <= (state_s == S_RESP);
      busy_r      <= (state_s != S_IDLE);
    end
  end

  assign req_ready  = grant_vec_s;
  assign core_go    = go_r;
  assign core_data  = data_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = id_r;
  assign rsp_result = res_r;
  assign rsp_error  = err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_bit_diff_rr_sched.sv
// Bench for bit_diff_rr_sched: a behavioural core, requester and consumer
// models drive the DUT; a job-level reference model predicts every output
// each cycle from the arbitration and timing rules.
module tb_bit_diff_rr_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int RW      = $clog2(2*WIDTH+1);
  localparam int IDW     = $clog2(NUM_REQ);

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*WIDTH-1:0]   req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [IDW-1:0]             rsp_id;
  logic signed [RW-1:0]       rsp_result;
  logic                       rsp_error;
  logic                       core_go;
  logic [WIDTH-1:0]           core_data;
  logic signed [RW-1:0]       core_result;
  logic                       core_done;
  logic                       busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bit_diff_rr_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .core_go(core_go), .core_data(core_data), .core_result(core_result),
    .core_done(core_done), .busy(busy)
  );

  // Behavioural core: latency chosen per job, optional hang, done held until
  // the cycle after the next go, garbage on result while not done.
  int               lat_cfg = 0;
  logic             stuck_cfg = 1'b0;
  logic             core_arm;
  int               core_cnt;
  logic [WIDTH-1:0] core_op;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_done <= 1'b0; core_result <= '0; core_arm <= 1'b0; core_cnt <= 0; core_op <= '0;
    end else if (core_go) begin
      core_arm <= 1'b1; core_cnt <= lat_cfg; core_op <= core_data;
    end else if (core_arm) begin
      if (!stuck_cfg && core_cnt == 0) begin
        core_done   <= 1'b1;
        core_result <= RW'(2*$countones(core_op) - WIDTH);
        core_arm    <= 1'b0;
      end else begin
        core_done   <= 1'b0;
        core_result <= RW'($urandom);
        if (core_cnt > 0) core_cnt <= core_cnt - 1;
      end
    end
  end

  // Reference model state (job level)
  logic             job_act = 1'b0;
  int               age = 0;
  int               cur_id = 0;
  logic [WIDTH-1:0] cur_data = '0;
  logic             cur_stuck = 1'b0;
  int               cur_wait = 1;
  int               mptr = 0;
  int               jobs_done = 0;
  // Stimulus knobs
  logic [NUM_REQ-1:0] granted_prev = '0;
  logic [NUM_REQ-1:0] stage_v = '0;
  logic [WIDTH-1:0]   stage_d [NUM_REQ];
  int   req_pct = 0;
  int   rdy_mode = 1;      // 0 random, 1 always ready, 2 never ready
  logic hold_all = 1'b0;
  logic force_stuck = 1'b0;
  logic rand_stuck = 1'b0;
  int   force_lat = -1;
  // Observed handshakes
  logic signed [31:0] obs_id[$];
  logic signed [31:0] obs_res[$];
  logic signed [31:0] obs_err[$];

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_diff(input logic [WIDTH-1:0] d);
    int ones = 0;
    for (int b = 0; b < WIDTH; b++) ones += int'(d[b]);
    return ones - (WIDTH - ones);
  endfunction

  task automatic raise(input int i, input logic [WIDTH-1:0] d);
    stage_v[i] = 1'b1;
    stage_d[i] = d;
  endtask

  // One cycle: drive inputs after the falling edge, then check everything.
  task automatic step();
    int g;
    int idx;
    logic [NUM_REQ-1:0] exp_rdy;
    logic exp_rv;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (granted_prev[i]) begin
        if (hold_all) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        else req_valid[i] = 1'b0;
      end
      if (stage_v[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*WIDTH +: WIDTH] = stage_d[i];
      end else if (!req_valid[i] && $urandom_range(99) < req_pct) begin
        req_valid[i] = 1'b1;
        req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
    end
    granted_prev = '0;
    stage_v = '0;
    rsp_ready = (rdy_mode == 0) ? ($urandom_range(99) < 70) : (rdy_mode == 1);
    #1;
    if (job_act) age++;
    exp_rdy = '0;
    g = -1;
    if (!job_act) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (mptr + k) % NUM_REQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(job_act));
    chk("core_go", 32'(core_go), 32'(job_act && age == 1));
    exp_rv = job_act && (age >= 3 + cur_wait);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (job_act) chk("core_data", 32'(core_data), 32'(cur_data));
    if (exp_rv) begin
      chk("rsp_id", 32'(rsp_id), cur_id);
      chk("rsp_result", 32'(rsp_result), cur_stuck ? 0 : ref_diff(cur_data));
      chk("rsp_error", 32'(rsp_error), cur_stuck ? 1 : 0);
      if (rsp_ready) begin
        obs_id.push_back(32'(rsp_id));
        obs_res.push_back(32'(rsp_result));
        obs_err.push_back(32'(rsp_error));
        job_act = 1'b0;
        jobs_done++;
      end
    end
    if (g >= 0) begin
      job_act   = 1'b1;
      age       = 0;
      cur_id    = g;
      cur_data  = req_data[g*WIDTH +: WIDTH];
      cur_stuck = force_stuck || (rand_stuck && $urandom_range(19) == 0);
      force_stuck = 1'b0;
      lat_cfg   = (force_lat >= 0) ? force_lat : int'($urandom_range(12));
      force_lat = -1;
      stuck_cfg = cur_stuck;
      cur_wait  = cur_stuck ? TIMEOUT : lat_cfg + 1;
      mptr      = (g + 1) % NUM_REQ;
      granted_prev[g] = 1'b1;
    end
  endtask

  task automatic run_jobs(input int n, input int budget);
    int start = jobs_done;
    int c = 0;
    while (jobs_done < start + n && c < budget) begin step(); c++; end
    chk("job_budget", jobs_done - start, n);
  endtask

  task automatic run_idle(input int budget);
    int c = 0;
    while ((job_act || req_valid != '0 || stage_v != '0) && c < budget) begin step(); c++; end
    chk("drain_budget", 32'(job_act || req_valid != '0), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_rsp_result"}, 32'(rsp_result), 0);
    chk({tag, "_rsp_error"}, 32'(rsp_error), 0);
    chk({tag, "_core_go"}, 32'(core_go), 0);
    chk({tag, "_core_data"}, 32'(core_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Asynchronous reset pulse between clock edges; v = requests pending across it.
  task automatic do_reset(input logic [NUM_REQ-1:0] v);
    @(posedge clk);
    #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
    req_valid = v;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    job_act = 1'b0; age = 0; mptr = 0; granted_prev = '0; stage_v = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) stage_d[i] = '0;
    #1;
    chk_zero("reset");
    @(posedge clk); #2; rst = 1'b0;

    // Basic results: all ones, all zeros, balanced
    raise(0, 8'hFF); run_jobs(1, 100);
    chk("t1_id", obs_id[$], 0); chk("t1_res", obs_res[$], 8); chk("t1_err", obs_err[$], 0);
    raise(2, 8'h00); run_jobs(1, 100);
    chk("t2_id", obs_id[$], 2); chk("t2_res", obs_res[$], -8);
    raise(1, 8'hA5); run_jobs(1, 100);
    chk("t2b_id", obs_id[$], 1); chk("t2b_res", obs_res[$], 0);

    // Round-robin order with everyone requesting continuously
    do_reset('0);
    hold_all = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) raise(i, WIDTH'($urandom));
    run_jobs(6, 200);
    for (int j = 0; j < 6; j++) chk("t3_order", obs_id[obs_id.size() - 6 + j], j % NUM_REQ);
    hold_all = 1'b0;
    run_idle(200);

    // Hung core triggers timeout; next job recovers
    force_stuck = 1'b1; raise(3, 8'h0F); run_jobs(1, 200);
    chk("t4_err", obs_err[$], 1); chk("t4_res", obs_res[$], 0);
    raise(3, 8'h3F); run_jobs(1, 100);
    chk("t4b_err", obs_err[$], 0); chk("t4b_res", obs_res[$], 4);

    // Consumer stalls; responses stay stable and no grant is issued
    rdy_mode = 2;
    raise(0, 8'h01); raise(2, 8'h7F);
    begin
      int c = 0;
      while (!rsp_valid && c < 100) begin step(); c++; end
    end
    chk("t5_rsp_seen", 32'(rsp_valid), 1);
    repeat (10) step();
    rdy_mode = 1;
    run_jobs(2, 200);
    chk("t5_first", obs_id[$-1], 0); chk("t5_second", obs_id[$], 2);

    // Reset mid-WAIT; first post-reset grant to lowest valid index
    force_lat = 10; raise(3, 8'h77);
    begin
      int c = 0;
      while (!(job_act && age == 5) && c < 50) begin step(); c++; end
    end
    do_reset(4'b0110);
    run_jobs(2, 200);
    chk("t6_first", obs_id[$-1], 1); chk("t6_second", obs_id[$], 2);

    // Random traffic
    req_pct = 25; rdy_mode = 0; rand_stuck = 1'b1;
    repeat (1500) step();
    req_pct = 0; rdy_mode = 1; rand_stuck = 1'b0;
    run_idle(500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
